// File: rtl/sc_sng_pkg.sv
// Shared definitions for the correlated stochastic number generator pair:
// FSM state type, maximal-length LFSR tap masks and seed sanitising.
package sc_sng_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Fibonacci tap mask for a shift-left LFSR: bit (n-1) set for each x^n term
  // of the feedback polynomial (the constant term is implicit).
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      4:       taps = 16'h000C; // x^4+x^3+1
      5:       taps = 16'h0014; // x^5+x^3+1
      6:       taps = 16'h0030; // x^6+x^5+1
      7:       taps = 16'h0060; // x^7+x^6+1
      8:       taps = 16'h00B8; // x^8+x^6+x^5+x^4+1
      9:       taps = 16'h0110; // x^9+x^5+1
      10:      taps = 16'h0240; // x^10+x^7+1
      11:      taps = 16'h0500; // x^11+x^9+1
      12:      taps = 16'h0829; // x^12+x^6+x^4+x^1+1
      13:      taps = 16'h100D; // x^13+x^4+x^3+x^1+1
      14:      taps = 16'h2015; // x^14+x^5+x^3+x^1+1
      15:      taps = 16'h6000; // x^15+x^14+1
      16:      taps = 16'hD008; // x^16+x^15+x^13+x^4+1
      default: taps = 16'h000C;
    endcase
    return taps;
  endfunction

  // An all-zero LFSR state locks up, so a zero seed is promoted to 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] seed);
    return (seed == 16'd0) ? 16'd1 : seed;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR (shift left, feedback into the LSB) with a
// synchronous reload to the seed. Reload wins over stepping.
module sc_lfsr
  import sc_sng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED_T = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(seed_fix(16'(SEED_T)));

  // Seed on reset or load, otherwise step once per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED_V;
    end else if (load) begin
      state <= SEED_V;
    end else if (en) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/sc_sng_pair.sv
// Binary-to-stochastic encoder producing two maximally correlated unipolar
// streams. Both operands are compared against the same LFSR value every
// cycle, so the ones of the smaller stream are a subset of the larger one.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The load port accepts only in IDLE (in_ready); the stream port
// holds its bit pair, bs_last and all internal state while bs_ready is low.
module sc_sng_pair
  import sc_sng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  output logic             bs_valid,
  input  logic             bs_ready,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bs_last,
  output logic             dbg_state
);

  // Index of the final pair: the stream is 2^WIDTH-1 bits long.
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'((1 << WIDTH) - 2);

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] val_a_q;
  logic [WIDTH-1:0] val_b_q;
  logic [WIDTH-1:0] lfsr_q;
  logic             accept;
  logic             xfer;

  assign in_ready  = (state_q == IDLE);
  assign bs_valid  = (state_q == RUN);
  assign accept    = in_valid & in_ready;
  assign xfer      = bs_valid & bs_ready;
  assign bit_a     = bs_valid & (lfsr_q <= val_a_q);
  assign bit_b     = bs_valid & (lfsr_q <= val_b_q);
  assign bs_last   = bs_valid & (cnt_q == LAST_CNT);
  assign dbg_state = (state_q == RUN);

  sc_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (xfer),
    .state (lfsr_q)
  );

  // Control FSM: latch operands on accept, count transfers, return to IDLE
  // when the final pair is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_a_q <= '0;
      val_b_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            val_a_q <= value_a;
            val_b_q <= value_b;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bs_ready) begin
            cnt_q <= cnt_q + WIDTH'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_sng_pair.sv
// Bench for sc_sng_pair: three instances (W=4 seed 1, W=8 seed 1, W=4 seed 0)
// share the clock, reset and stream-ready; a selector routes the load port.
module tb_sc_sng_pair;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared drive signals ----------------
  int         sel;
  logic       iv;
  logic       br;
  logic [7:0] va;
  logic [7:0] vb;

  logic       iv4, ir4, bv4, ba4, bb4, bl4, ds4;
  logic [3:0] va4, vb4;
  logic       iv8, ir8, bv8, ba8, bb8, bl8, ds8;
  logic [7:0] va8, vb8;
  logic       ivz, irz, bvz, baz, bbz, blz, dsz;
  logic [3:0] vaz, vbz;

  assign iv4 = iv & (sel == 0);
  assign iv8 = iv & (sel == 1);
  assign ivz = iv & (sel == 2);
  assign va4 = va[3:0];
  assign vb4 = vb[3:0];
  assign va8 = va;
  assign vb8 = vb;
  assign vaz = va[3:0];
  assign vbz = vb[3:0];

  sc_sng_pair #(.WIDTH(4), .SEED(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .value_a(va4), .value_b(vb4), .bs_valid(bv4), .bs_ready(br),
    .bit_a(ba4), .bit_b(bb4), .bs_last(bl4), .dbg_state(ds4)
  );

  sc_sng_pair #(.WIDTH(8), .SEED(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .value_a(va8), .value_b(vb8), .bs_valid(bv8), .bs_ready(br),
    .bit_a(ba8), .bit_b(bb8), .bs_last(bl8), .dbg_state(ds8)
  );

  sc_sng_pair #(.WIDTH(4), .SEED(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivz), .in_ready(irz),
    .value_a(vaz), .value_b(vbz), .bs_valid(bvz), .bs_ready(br),
    .bit_a(baz), .bit_b(bbz), .bs_last(blz), .dbg_state(dsz)
  );

  // Selected instance's outputs.
  logic m_ir, m_bv, m_a, m_b, m_l, m_ds;
  always_comb begin
    m_ir = ir4; m_bv = bv4; m_a = ba4; m_b = bb4; m_l = bl4; m_ds = ds4;
    case (sel)
      1: begin m_ir = ir8; m_bv = bv8; m_a = ba8; m_b = bb8; m_l = bl8; m_ds = ds8; end
      2: begin m_ir = irz; m_bv = bvz; m_a = baz; m_b = bbz; m_l = blz; m_ds = dsz; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected LFSR visit order, derived from the feedback polynomial.
  int seq[$];

  function automatic int poly_taps(input int w);
    return (w == 8) ? 'hB8 : 'hC; // x^8+x^6+x^5+x^4+1 / x^4+x^3+1
  endfunction

  task automatic gen_seq(input int w, input int seed);
    int x;
    int mask;
    mask = (1 << w) - 1;
    x = seed & mask;
    if (x == 0) x = 1;
    seq.delete();
    for (int i = 0; i < mask; i++) begin
      seq.push_back(x);
      x = ((x << 1) | ($countones(x & poly_taps(w)) & 1)) & mask;
    end
  endtask

  // ---------------- driver / monitor ----------------
  // Called just after a falling edge with the selected instance idle. Offers
  // (a,b), then consumes the stream with bs_ready high pct% of cycles.
  // abort_at >= 0 stops (bs_ready low) once that many pairs have transferred.
  // hold keeps in_valid high with (ha,hb) throughout the stream.
  task automatic run_stream(input int s, input int a, input int b, input int pct,
                            input int abort_at, input int hold, input int ha, input int hb,
                            output int ones_a, output int ones_b);
    int w, len, idx, cycles;
    logic pa, pb, pl, prev_xfer;
    sel = s;
    w = (s == 1) ? 8 : 4;
    len = (1 << w) - 1;
    gen_seq(w, (s == 2) ? 0 : 1);
    #1;
    chk("accept_ready", m_ir, 1);
    iv = 1'b1; va = 8'(a); vb = 8'(b); br = 1'b0;
    @(negedge clk);
    if (hold != 0) begin va = 8'(ha); vb = 8'(hb); end
    else iv = 1'b0;
    idx = 0; cycles = 0; ones_a = 0; ones_b = 0;
    prev_xfer = 1'b1; pa = 1'b0; pb = 1'b0; pl = 1'b0;
    while (idx < len && cycles < len * 20) begin
      chk("bs_valid", m_bv, 1);
      chk("in_ready_run", m_ir, 0);
      chk("dbg_run", m_ds, 1);
      chk("bit_a", m_a, (seq[idx] <= a) ? 1 : 0);
      chk("bit_b", m_b, (seq[idx] <= b) ? 1 : 0);
      chk("bs_last", m_l, (idx == len - 1) ? 1 : 0);
      if (a <= b) chk("corr_ab", m_a & ~m_b, 0);
      else        chk("corr_ba", m_b & ~m_a, 0);
      if (!prev_xfer) chk("stall_hold", {m_a, m_b, m_l}, {pa, pb, pl});
      if (abort_at == idx) begin
        br = 1'b0;
        break;
      end
      br = ($urandom_range(99) < pct);
      pa = m_a; pb = m_b; pl = m_l; prev_xfer = br;
      if (br) begin
        ones_a += int'(m_a);
        ones_b += int'(m_b);
        idx++;
      end
      @(negedge clk);
      cycles++;
    end
    br = 1'b0;
    if (abort_at < 0) begin
      chk("stream_len", idx, len);
      chk("idle_ready", m_ir, 1);
      chk("idle_valid", m_bv, 0);
      chk("idle_bits", {m_a, m_b, m_l, m_ds}, 0);
    end
  endtask

  // ---------------- table ----------------
  typedef struct {
    int s;
    int a;
    int b;
    int pct;
    int exp_a;
    int exp_b;
  } vec_t;

  vec_t tbl[8];

  task automatic chk_reset_outputs(input int s);
    sel = s;
    #1;
    chk("rst_ready", m_ir, 1);
    chk("rst_outs", {m_bv, m_a, m_b, m_l, m_ds}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int oa, ob, ra, rb;
    tbl[0] = '{0,   0,  15, 100,   0,  15};
    tbl[1] = '{0,   5,  10, 100,   5,  10};
    tbl[2] = '{0,  15,   0,  60,  15,   0};
    tbl[3] = '{0,   7,   7,  50,   7,   7};
    tbl[4] = '{1, 200,  37,  50, 200,  37};
    tbl[5] = '{1, 255,   0,  70, 255,   0};
    tbl[6] = '{2,   5,  10, 100,   5,  10};
    tbl[7] = '{2,   1,  14,  50,   1,  14};

    sel = 0; iv = 1'b0; br = 1'b0; va = '0; vb = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int s = 0; s < 3; s++) chk_reset_outputs(s);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven streams.
    for (int i = 0; i < 8; i++) begin
      run_stream(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].pct, -1, 0, 0, 0, oa, ob);
      chk($sformatf("ones_a[%0d]", i), oa, tbl[i].exp_a);
      chk($sformatf("ones_b[%0d]", i), ob, tbl[i].exp_b);
    end

    // Random W=8 operands with random stalls.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(255);
      rb = $urandom_range(255);
      run_stream(1, ra, rb, 80, -1, 0, 0, 0, oa, ob);
      chk("rand_ones_a", oa, ra);
      chk("rand_ones_b", ob, rb);
    end

    // in_valid held with new operands during RUN; second pair accepted right
    // after the first stream ends.
    run_stream(0, 4, 9, 70, -1, 1, 11, 2, oa, ob);
    chk("hold_ones_a", oa, 4);
    chk("hold_ones_b", ob, 9);
    run_stream(0, 11, 2, 100, -1, 0, 0, 0, oa, ob);
    chk("hold2_ones_a", oa, 11);
    chk("hold2_ones_b", ob, 2);

    // Asynchronous reset in the middle of a stream, then a fresh stream.
    run_stream(0, 9, 12, 100, 7, 0, 0, 0, oa, ob);
    chk("pre_rst_ones_a", oa, 7 - 0 >= 0 ? oa : 0);
    #2 rst_n = 1'b0;
    chk_reset_outputs(0);
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(0, 3, 3, 100, -1, 0, 0, 0, oa, ob);
    chk("post_rst_ones_a", oa, 3);
    chk("post_rst_ones_b", ob, 3);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
